gate_vector_sequencer: RTL and testbench
========================================

// Module: gate_vector_sequencer
// PURPOSE
//  Sequences a combinational gate network (4 inputs A,B,C,D -> 3 outputs X,Y,Z).
//  Holds a loadable table of stimulus/expected pairs and applies them one at a time.
//  Waits a programmable settle time after each vector, then compares the network outputs.
//  Reports error count, first failing index and pass/done. Sits beside the gate network
//  as its on-chip self-check controller.
// PARAMETERS
//  DEPTH   16               number of vector table entries
//  SETTLE  1                wait cycles between applying abcd and sampling xyz (>=0)
//  AW      $clog2(DEPTH)    table index width (derived; do not override)
// PORTS
//  clk            in   1      single clock, all state on rising edge
//  rst            in   1      synchronous, active-high reset
//  wr_en          in   1      table write strobe
//  wr_addr        in   AW     table write index
//  wr_vec         in   4      stimulus {A,B,C,D}
//  wr_exp         in   3      expected {X,Y,Z}
//  num_vec        in   AW+1   vectors to run; sampled on accepted start
//  start          in   1      run request (level sampled in IDLE)
//  abcd           out  4      drives network {A,B,C,D}
//  xyz            in   3      network outputs {X,Y,Z}
//  busy           out  1      state != IDLE
//  done           out  1      one-cycle pulse at end of run
//  pass           out  1      err_cnt==0 for last completed run
//  err_cnt        out  AW+1   mismatching vectors in current/last run
//  first_err_idx  out  AW     index of first mismatch
//  first_err_vld  out  1      first_err_idx is valid
// BEHAVIOUR
//  Reset values: state=IDLE, abcd=0, busy=0, done=0, pass=0, err_cnt=0,
//   first_err_idx=0, first_err_vld=0, idx=0. Table contents are NOT reset.
//  FSM states: IDLE, APPLY, WAIT, CHECK, FIN.
//   IDLE : start=1 -> clear err_cnt/first_err_*/pass; latch n=min(num_vec,DEPTH); idx=0.
//          n==0 -> FIN, else APPLY.
//   APPLY: abcd <= table[idx].vec (registered; visible next cycle).
//          Next state is WAIT, or CHECK when SETTLE==0.
//   WAIT : count SETTLE cycles, then CHECK.
//   CHECK: compare xyz to table[idx].exp. On mismatch: err_cnt++; if !first_err_vld,
//          set first_err_idx=idx and first_err_vld=1. Then idx==n-1 -> FIN,
//          else idx++ and go to APPLY.
//   FIN  : done=1 for this cycle only; pass=(err_cnt==0) registered; -> IDLE.
//  Timing: per vector = 2+SETTLE cycles. If start is seen in cycle 0, done is in cycle
//   1+n*(2+SETTLE). For n==0, done is in cycle 1.
//  abcd holds the last applied vector after the run until the next APPLY or rst.
//  start while busy: ignored. wr_en while busy: ignored (table stable during run).
//   wr_en in IDLE together with start: write takes effect; the run reads the new value.
//  err_cnt cannot overflow (max DEPTH, fits AW+1).
//  pass/err_cnt/first_err_* hold until the next accepted start or rst.
//  rst mid-run: all outputs return to reset values the next cycle. No done pulse.
//   Table is retained.
// STRUCTURE
//  Package gate_seq_pkg:
//   - state_t enum {IDLE,APPLY,WAIT,CHECK,FIN}
//   - vec_entry_t struct {logic [3:0] vec; logic [2:0] exp}
//  Sub-module gate_vec_mem: DEPTH x vec_entry_t register file, one sync write port,
//   one async read port.
//  Top holds the FSM, settle counter, idx and result registers.
// TESTING (bench network model: X=A&B&C, Y=~(C|D), Z=B^D)
//  1 SETTLE=1; load 0000/010, 1001/001, 1110/101, 0111/000, 1111/100; num_vec=5;
//    start -> abcd steps through the 5 vectors; done pulse at cycle 16;
//    err_cnt=0, pass=1, first_err_vld=0.
//  2 Same as 1 but entry 2 exp=3'b111 -> err_cnt=1, first_err_idx=2,
//    first_err_vld=1, pass=0.
//  3 num_vec=0; start -> done at cycle 1, pass=1, abcd unchanged.
//  4 rst=1 during WAIT of idx 3 -> next cycle busy=0, abcd=0, err_cnt=0, no done;
//    rerun of test 1 gives the same results (table retained).
//  5 start and wr_en pulsed mid-run -> ignored, table unchanged;
//    DEPTH=16, num_vec=20 -> exactly 16 vectors applied.
//  6 SETTLE=0 -> per-vector period 2 cycles; n=5 -> done at cycle 11.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared types for the gate-network self-check sequencer: FSM states and
// one vector-table entry (stimulus plus expected response).
package gate_seq_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned EXP_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    FIN
  } state_t;

  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [EXP_W-1:0] exp;
  } vec_entry_t;

endpackage

// File: rtl/gate_vec_mem.sv
// Vector table: DEPTH entries, one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module gate_vec_mem
  import gate_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  vec_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output vec_entry_t    rdata
);

  vec_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/gate_vector_sequencer.sv
// Applies stored stimulus vectors to a gate network, waits SETTLE cycles,
// compares the response and accumulates error count / first failing index.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_vec,
  input  logic [2:0]    wr_exp,
  input  logic [AW:0]   num_vec,
  input  logic          start,
  output logic [3:0]    abcd,
  input  logic [2:0]    xyz,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_idx,
  output logic          first_err_vld
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t        state_q, state_d;
  logic [3:0]    abcd_q, abcd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] first_err_idx_q, first_err_idx_d;
  logic          first_err_vld_q, first_err_vld_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  vec_entry_t    rd_entry;

  gate_vec_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en && (state_q == IDLE)),
    .waddr (wr_addr),
    .wdata ('{vec: wr_vec, exp: wr_exp}),
    .raddr (idx_q),
    .rdata (rd_entry)
  );

  always_comb begin
    state_d         = state_q;
    abcd_d          = abcd_q;
    pass_d          = pass_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vld_d = first_err_vld_q;
    idx_d           = idx_q;
    n_d             = n_q;
    cnt_d           = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_cnt_d       = '0;
          first_err_idx_d = '0;
          first_err_vld_d = 1'b0;
          pass_d          = 1'b0;
          idx_d           = '0;
          n_d             = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
          state_d         = (n_d == '0) ? FIN : APPLY;
        end
      end
      APPLY: begin
        abcd_d  = rd_entry.vec;
        cnt_d   = '0;
        state_d = (SETTLE == 0) ? CHECK : WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CHECK: begin
        if (xyz != rd_entry.exp) begin
          err_cnt_d = err_cnt_q + (AW+1)'(1);
          if (!first_err_vld_q) begin
            first_err_idx_d = idx_q;
            first_err_vld_d = 1'b1;
          end
        end
        if ({1'b0, idx_q} == n_q - (AW+1)'(1)) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = APPLY;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flags are set on entry to FIN so pass is already valid alongside done.
    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE);
    if (state_d == FIN) begin
      pass_d = (err_cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      abcd_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
      idx_q           <= '0;
      n_q             <= '0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      abcd_q          <= abcd_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vld_q <= first_err_vld_d;
      idx_q           <= idx_d;
      n_q             <= n_d;
      cnt_q           <= cnt_d;
    end
  end

  assign abcd          = abcd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: two instances (SETTLE=1 and SETTLE=0) driving
// a modelled gate network, checked against a table-level reference model.
module tb_gate_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst, wr_en, start, start0;
  logic [3:0] wr_addr, wr_vec;
  logic [2:0] wr_exp;
  logic [4:0] num_vec;

  logic [3:0] abcd1, abcd0, fidx1, fidx0;
  logic [2:0] xyz1, xyz0;
  logic       busy1, busy0, done1, done0, pass1, pass0, fvld1, fvld0;
  logic [4:0] err1, err0;

  logic [3:0] m_vec [16];
  logic [2:0] m_exp [16];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] net(input logic [3:0] v);
    return {v[3] & v[2] & v[1], ~(v[1] | v[0]), v[2] ^ v[0]};
  endfunction

  assign xyz1 = net(abcd1);
  assign xyz0 = net(abcd0);

  gate_vector_sequencer #(.DEPTH(16), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_vec(wr_vec),
    .wr_exp(wr_exp), .num_vec(num_vec), .start(start), .abcd(abcd1), .xyz(xyz1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_idx(fidx1), .first_err_vld(fvld1)
  );

  gate_vector_sequencer #(.DEPTH(16), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_vec(wr_vec),
    .wr_exp(wr_exp), .num_vec(num_vec), .start(start0), .abcd(abcd0), .xyz(xyz0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_idx(fidx0), .first_err_vld(fvld0)
  );

  task automatic write_entry(input int a, input logic [3:0] v, input logic [2:0] e);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_vec = v; wr_exp = e;
    m_vec[a] = v; m_exp[a] = e;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_test1();
    write_entry(0, 4'b0000, 3'b010);
    write_entry(1, 4'b1001, 3'b001);
    write_entry(2, 4'b1110, 3'b101);
    write_entry(3, 4'b0111, 3'b000);
    write_entry(4, 4'b1111, 3'b100);
  endtask

  task automatic load_random(input int cnt);
    logic [3:0] v;
    logic [2:0] e;
    for (int k = 0; k < cnt; k++) begin
      v = 4'($urandom);
      e = ($urandom_range(0, 1) == 0) ? net(v) : 3'($urandom);
      write_entry(k, v, e);
    end
  endtask

  // Runs one sequence on the selected instance and checks timing and results.
  task automatic do_run(input bit s0, input int nv, input string tag, input bit disturb);
    int n, per, exp_done, errs, ferr, done_at, done_cnt, i;
    logic [3:0] prev, obs_a, fin_a;
    logic [4:0] obs_err;
    logic       obs_vld, obs_pass;
    logic [3:0] obs_idx;
    n = (nv > 16) ? 16 : nv;
    per = s0 ? 2 : 3;
    exp_done = 1 + n * per;
    errs = 0; ferr = -1;
    for (int k = 0; k < n; k++) begin
      if (net(m_vec[k]) !== m_exp[k]) begin
        errs++;
        if (ferr < 0) ferr = k;
      end
    end
    @(negedge clk);
    prev = s0 ? abcd0 : abcd1;
    num_vec = 5'(nv);
    if (s0) start0 = 1'b1; else start = 1'b1;
    done_at = -1; done_cnt = 0;
    for (int c = 1; c <= exp_done + 4; c++) begin
      @(negedge clk);
      start = 1'b0; start0 = 1'b0; wr_en = 1'b0;
      if (disturb && c == 4) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd15;
        wr_vec = ~m_vec[15]; wr_exp = ~m_exp[15];
      end
      obs_a = s0 ? abcd0 : abcd1;
      if ((s0 ? done0 : done1) === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c >= 2 && c < 2 + n * per && (c - 2) % per == 0) begin
        i = (c - 2) / per;
        n_cmp++;
        if (obs_a !== m_vec[i]) begin
          n_err++;
          $display("FAIL %s abcd[%0d]: got %b want %b", tag, i, obs_a, m_vec[i]);
        end
      end
    end
    obs_err = s0 ? err0 : err1;
    obs_vld = s0 ? fvld0 : fvld1;
    obs_idx = s0 ? fidx0 : fidx1;
    obs_pass = s0 ? pass0 : pass1;
    fin_a = s0 ? abcd0 : abcd1;
    n_cmp++;
    if (done_at != exp_done) begin
      n_err++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_at, exp_done);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt);
    end
    n_cmp++;
    if (obs_err !== 5'(errs)) begin
      n_err++; $display("FAIL %s err_cnt: got %0d want %0d", tag, obs_err, errs);
    end
    n_cmp++;
    if (obs_vld !== (ferr >= 0)) begin
      n_err++; $display("FAIL %s first_err_vld: got %b want %b", tag, obs_vld, ferr >= 0);
    end
    n_cmp++;
    if (obs_idx !== ((ferr >= 0) ? 4'(ferr) : 4'd0)) begin
      n_err++; $display("FAIL %s first_err_idx: got %0d want %0d", tag, obs_idx, ferr);
    end
    n_cmp++;
    if (obs_pass !== (errs == 0)) begin
      n_err++; $display("FAIL %s pass: got %b want %b", tag, obs_pass, errs == 0);
    end
    n_cmp++;
    if (fin_a !== ((n == 0) ? prev : m_vec[n-1])) begin
      n_err++; $display("FAIL %s abcd_hold: got %b want %b", tag, fin_a, (n == 0) ? prev : m_vec[n-1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; start0 = 1'b0;
    wr_addr = '0; wr_vec = '0; wr_exp = '0; num_vec = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({abcd1, busy1, done1, pass1, err1, fidx1, fvld1} !== 20'd0) begin
      n_err++; $display("FAIL reset_dut: got %h want 0", {abcd1, busy1, done1, pass1, err1, fidx1, fvld1});
    end
    n_cmp++;
    if ({abcd0, busy0, done0, pass0, err0, fidx0, fvld0} !== 20'd0) begin
      n_err++; $display("FAIL reset_dut0: got %h want 0", {abcd0, busy0, done0, pass0, err0, fidx0, fvld0});
    end
  endtask

  task automatic test_basic();
    load_test1();
    do_run(1'b0, 5, "basic", 1'b0);
  endtask

  task automatic test_error();
    write_entry(2, 4'b1110, 3'b111);
    do_run(1'b0, 5, "one_err", 1'b0);
  endtask

  task automatic test_zero();
    do_run(1'b0, 0, "zero_vec", 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    write_entry(2, 4'b1110, 3'b101);
    @(negedge clk);
    num_vec = 5'd5; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_err++; $display("FAIL mid_busy: got %b want 1", busy1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy1, abcd1, err1, done1, pass1, fvld1} !== 13'd0) begin
      n_err++; $display("FAIL mid_rst_outputs: got %h want 0", {busy1, abcd1, err1, done1, pass1, fvld1});
    end
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done1 === 1'b1) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0) begin
      n_err++; $display("FAIL mid_rst_no_done: got %0d pulses want 0", seen_done);
    end
    do_run(1'b0, 5, "rerun", 1'b0);
  endtask

  task automatic test_back_to_back();
    load_random(16);
    do_run(1'b0, 20, "clip_disturb", 1'b1);
    do_run(1'b0, 16, "table_kept", 1'b0);
    do_run(1'b0, $urandom_range(1, 15), "rand_len", 1'b0);
  endtask

  task automatic test_settle0();
    load_random(5);
    do_run(1'b1, 5, "settle0", 1'b0);
    write_entry(1, m_vec[1], ~net(m_vec[1]));
    do_run(1'b1, 5, "settle0_err", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_settle0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
